// File: rtl/tribus_arb.sv
// tribus_arb: round-robin arbiter producing one-hot registered enables
// for N tribuf drivers sharing one bus, with turnaround and hold limit.
//
// Ports:
//   CK      in   clock, rising edge
//   RN      in   asynchronous active-low reset
//   REQ     in   [N] level requests
//   GNT     out  [N] registered one-hot-or-zero grant (tribuf E pins)
//   BUSY    out  high while a grant is held
//   OWNER   out  [W] current or most recent owner index
//   TIMEOUT out  one-cycle pulse when MAXHOLD ends a tenure
module tribus_arb #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8,
    parameter int TURN    = 1,
    localparam int W      = (N > 2) ? $clog2(N) : 1
) (
    input  logic         CK,
    input  logic         RN,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic         BUSY,
    output logic [W-1:0] OWNER,
    output logic         TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_e;

    localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);
    localparam logic [3:0] TURN_LEN = 4'(TURN);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   owner_q, owner_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           tout_q, tout_d;
    logic [7:0]     hold_q, hold_d;
    logic [3:0]     turn_q, turn_d;

    logic           any;
    logic [W-1:0]   win;
    logic           do_grant;
    logic           do_rel;

    // First requester at or above the pointer, wrapping modulo N.
    always_comb begin : p_win
        int j;
        j   = 0;
        any = 1'b0;
        win = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!any && REQ[j]) begin
                any = 1'b1;
                win = W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        tout_d   = 1'b0;
        hold_d   = hold_q;
        turn_d   = turn_q;
        do_grant = 1'b0;
        do_rel   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                do_grant = any;
            end
            ST_OWN: begin
                // Owner drop wins over the hold limit at the same edge.
                if (!REQ[owner_q]) begin
                    do_rel = 1'b1;
                end else if (hold_q == HOLD_MAX) begin
                    do_rel = 1'b1;
                    tout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_TURN: begin
                turn_d = turn_q - 4'd1;
                if (turn_q == 4'd1) begin
                    if (any) do_grant = 1'b1;
                    else     state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (do_grant) begin
            gnt_d   = '0;
            gnt_d[win] = 1'b1;
            busy_d  = 1'b1;
            owner_d = win;
            hold_d  = 8'd1;
            state_d = ST_OWN;
        end

        // A released owner goes to the back of the rotation.
        if (do_rel) begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            turn_d  = TURN_LEN;
            state_d = ST_TURN;
            ptr_d   = (owner_q == W'(N - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            tout_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tout_q  <= tout_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign GNT     = gnt_q;
    assign BUSY    = busy_q;
    assign OWNER   = owner_q;
    assign TIMEOUT = tout_q;

endmodule

// File: tb/tb_tribus_arb.sv
// tb_tribus_arb: directed and randomized checks of tribus_arb
// against a cycle-level behavioural model of the arbitration rules.
module tb_tribus_arb;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       CK = 1'b0;
    logic       RN;
    logic [3:0] REQ, REQ3;
    logic [3:0] GNT, GNT3;
    logic       BUSY, BUSY3, TO, TO3;
    logic [1:0] OWN, OWN3;

    int total = 0;
    int bad   = 0;

    // Model: owner index or -1, tenure length, dead cycles left,
    // rotation start, last owner, timeout flag.
    int m_own, m_len, m_dead, m_ptr, m_last;
    bit m_to;

    always #5 CK = ~CK;

    tribus_arb #(.N(4), .MAXHOLD(4), .TURN(1)) dut (
        .CK(CK), .RN(RN), .REQ(REQ), .GNT(GNT),
        .BUSY(BUSY), .OWNER(OWN), .TIMEOUT(TO)
    );

    tribus_arb #(.N(4), .MAXHOLD(4), .TURN(3)) dut3 (
        .CK(CK), .RN(RN), .REQ(REQ3), .GNT(GNT3),
        .BUSY(BUSY3), .OWNER(OWN3), .TIMEOUT(TO3)
    );

    always @(negedge CK) begin
        total++;
        if ($countones(GNT) > 1 || $countones(GNT3) > 1) begin
            bad++;
            $display("FAIL onehot: GNT=%b GNT3=%b required popcount<=1",
                     GNT, GNT3);
        end
    end

    task automatic mreset();
        m_own = -1; m_len = 0; m_dead = 0;
        m_ptr = 0; m_last = 0; m_to = 0;
    endtask

    task automatic mgrant(input logic [3:0] r);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (m_own < 0 && r[idx]) begin
                m_own = idx; m_last = idx; m_len = 1;
            end
        end
    endtask

    task automatic mrelease();
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_dead = 1;
    endtask

    task automatic mstep(input logic [3:0] r);
        bit may;
        m_to = 0;
        if (m_own >= 0) begin
            if (!r[m_own]) mrelease();
            else if (m_len == MH) begin
                mrelease();
                m_to = 1;
            end else m_len++;
        end else begin
            may = 1;
            if (m_dead > 0) begin
                m_dead--;
                may = (m_dead == 0);
            end
            if (may && r != 0) mgrant(r);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        mstep(REQ);
        #1;
    endtask

    task automatic do_reset();
        RN = 1'b0; REQ = '0; REQ3 = '0;
        mreset();
        repeat (2) @(posedge CK);
        #1 RN = 1'b1;
    endtask

    task automatic test_reset();
        RN = 1'b0; REQ = '0; REQ3 = '0;
        #1;
        total++;
        if ({GNT, BUSY, OWN, TO, GNT3} !== 12'b0) begin
            bad++;
            $display("FAIL reset: got %b %b %b %b %b required all zero",
                     GNT, BUSY, OWN, TO, GNT3);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        do_reset();
        REQ = 4'b0010;
        cyc();
        total++;
        if (GNT !== 4'b0010) begin
            bad++;
            $display("FAIL arst_pre: GNT=%b required 0010", GNT);
        end
        #2 RN = 1'b0;
        #1;
        mreset();
        total++;
        if ({GNT, BUSY, OWN} !== 7'b0) begin
            bad++;
            $display("FAIL arst_mid: GNT=%b BUSY=%b OWNER=%0d required 0",
                     GNT, BUSY, OWN);
        end
        @(posedge CK);
        #1 RN = 1'b1;
        cyc();
        total++;
        if (GNT !== 4'b0010 || OWN !== 2'd1) begin
            bad++;
            $display("FAIL arst_post: GNT=%b OWNER=%0d required 0010/1",
                     GNT, OWN);
        end
    endtask

    task automatic test_voluntary();
        do_reset();
        REQ = 4'b0010;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            total++;
            if (GNT !== 4'b0010 || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL vol_hold%0d: GNT=%b BUSY=%b required 0010/1",
                         k, GNT, BUSY);
            end
        end
        REQ = 4'b0000;
        cyc();
        total++;
        if (GNT !== 4'b0000 || TO !== 1'b0 || OWN !== 2'd1) begin
            bad++;
            $display("FAIL vol_rel: GNT=%b TO=%b OWNER=%0d required 0000/0/1",
                     GNT, TO, OWN);
        end
        repeat (2) cyc();
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || OWN !== 2'd1) begin
            bad++;
            $display("FAIL vol_idle: GNT=%b BUSY=%b OWNER=%0d required 0/0/1",
                     GNT, BUSY, OWN);
        end
    endtask

    task automatic test_contention();
        logic [3:0] e;
        do_reset();
        REQ = 4'b1111;
        for (int k = 1; k <= 25; k++) begin
            int p, idx;
            cyc();
            p   = (k - 1) % 5;
            idx = ((k - 1) / 5) % 4;
            e   = (p < 4) ? (4'b0001 << idx) : 4'b0000;
            total++;
            if (GNT !== e || TO !== (p == 4)) begin
                bad++;
                $display("FAIL contend k=%0d: GNT=%b TO=%b required %b/%0d",
                         k, GNT, TO, e, p == 4);
            end
        end
    endtask

    task automatic test_hog();
        logic [3:0] e;
        do_reset();
        REQ = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            int p;
            cyc();
            p = (k - 1) % 5;
            e = (p < 4) ? 4'b0100 : 4'b0000;
            total++;
            if (GNT !== e || OWN !== 2'd2 || TO !== (p == 4)) begin
                bad++;
                $display("FAIL hog k=%0d: GNT=%b OWNER=%0d TO=%b required %b/2",
                         k, GNT, OWN, TO, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        REQ = 4'b0001;
        repeat (4) cyc();
        total++;
        if (GNT !== 4'b0001) begin
            bad++;
            $display("FAIL simul_hold: GNT=%b required 0001", GNT);
        end
        REQ = 4'b0000;
        cyc();
        total++;
        if (GNT !== 4'b0000 || TO !== 1'b0) begin
            bad++;
            $display("FAIL simul_rel: GNT=%b TO=%b required 0000/0", GNT, TO);
        end
        cyc();
        total++;
        if (TO !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL simul_after: TO=%b BUSY=%b required 0/0", TO, BUSY);
        end
    endtask

    task automatic test_turn3();
        logic [3:0] e;
        do_reset();
        REQ3 = 4'b1001;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k <= 4)       e = 4'b0001;
            else if (k <= 7)  e = 4'b0000;
            else if (k <= 11) e = 4'b1000;
            else              e = 4'b0000;
            total++;
            if (GNT3 !== e || TO3 !== (k == 5 || k == 12)) begin
                bad++;
                $display("FAIL turn3 k=%0d: GNT=%b TO=%b required %b",
                         k, GNT3, TO3, e);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) REQ = 4'($urandom_range(0, 15));
            cyc();
            eg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
            total++;
            if (GNT !== eg || BUSY !== (m_own >= 0) ||
                OWN !== 2'(m_last) || TO !== m_to) begin
                bad++;
                $display("FAIL rand k=%0d: GNT=%b B=%b O=%0d T=%b required %b %0d %0d %0d",
                         k, GNT, BUSY, OWN, TO, eg, m_own >= 0, m_last, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_voluntary();
        test_contention();
        test_hog();
        test_simultaneous();
        test_turn3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
